// File: rtl/line_rasterizer_if.sv
// Segment-in and pixel-out handshake bundles
// for the Bresenham line rasterizer.
interface line_if #(
  parameter int COORD_W = 16
);
  logic                      line_valid;
  logic                      line_ready;
  logic signed [COORD_W-1:0] x0_in;
  logic signed [COORD_W-1:0] y0_in;
  logic signed [COORD_W-1:0] x1_in;
  logic signed [COORD_W-1:0] y1_in;

  modport master (
    output line_valid,
    output x0_in,
    output y0_in,
    output x1_in,
    output y1_in,
    input  line_ready
  );

  modport slave (
    input  line_valid,
    input  x0_in,
    input  y0_in,
    input  x1_in,
    input  y1_in,
    output line_ready
  );
endinterface

interface pix_if #(
  parameter int COORD_W = 16
);
  logic                      pix_valid;
  logic                      pix_ready;
  logic signed [COORD_W-1:0] pix_x;
  logic signed [COORD_W-1:0] pix_y;

  modport master (
    output pix_valid,
    output pix_x,
    output pix_y,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_x,
    input  pix_y,
    output pix_ready
  );
endinterface

// File: rtl/line_rasterizer.sv
// Bresenham line walker, one pixel per cycle.
// Optional on-screen filter: RAST_BOUNDS_CHECK_EN.
module line_rasterizer #(
  parameter int COORD_W  = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic  clkin,
  input  logic  rst_n,
  line_if.slave seg,
  pix_if.master pix,
  output logic  busy,
  output logic  line_done
);

  localparam int IW = COORD_W + 2;
  localparam int EW = COORD_W + 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    DONE
  } state_e;

  typedef logic signed [COORD_W-1:0] crd_t;
  typedef logic signed [IW-1:0]      wide_t;
  typedef logic signed [EW-1:0]      e2_t;

  localparam crd_t ONE = crd_t'(1);

  if (SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_screen
    $error("line_rasterizer: screen size must be positive");
  end

  function automatic wide_t absdiff(crd_t a, crd_t b);
    wide_t d;
    d = wide_t'(b) - wide_t'(a);
    return d[IW-1] ? -d : d;
  endfunction

`ifdef RAST_BOUNDS_CHECK_EN
  function automatic logic on_screen(crd_t x, crd_t y);
    return (int'(x) >= 0) && (int'(x) < SCREEN_W) &&
           (int'(y) >= 0) && (int'(y) < SCREEN_H);
  endfunction
`endif

  state_e state_q, state_d;
  crd_t   x0_q, x0_d, y0_q, y0_d;
  crd_t   x1_q, x1_d, y1_q, y1_d;
  crd_t   cx_q, cx_d, cy_q, cy_d;
  wide_t  dx_q, dx_d, dy_q, dy_d;
  wide_t  err_q, err_d;
  logic   sxn_q, sxn_d, syn_q, syn_d;
  logic   pix_valid_q, pix_valid_d;
  logic   line_ready_q, line_ready_d;

  e2_t  e2;
  logic step_x, step_y;
  logic at_end;
  logic step;

  assign e2     = {err_q, 1'b0};
  assign step_x = e2 >= e2_t'(dy_q);
  assign step_y = e2 <= e2_t'(dx_q);
  assign at_end = (cx_q == x1_q) && (cy_q == y1_q);

  // Off-screen points are skipped without waiting.
`ifdef RAST_BOUNDS_CHECK_EN
  assign step = pix.pix_ready || !pix_valid_q;
`else
  assign step = pix.pix_ready;
`endif

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    err_d        = err_q;
    sxn_d        = sxn_q;
    syn_d        = syn_q;
    pix_valid_d  = 1'b0;
    line_ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seg.line_valid && line_ready_q) begin
          x0_d    = seg.x0_in;
          y0_d    = seg.y0_in;
          x1_d    = seg.x1_in;
          y1_d    = seg.y1_in;
          state_d = SETUP;
        end
      end
      SETUP: begin
        dx_d    = absdiff(x0_q, x1_q);
        dy_d    = -absdiff(y0_q, y1_q);
        err_d   = absdiff(x0_q, x1_q)
                - absdiff(y0_q, y1_q);
        sxn_d   = !(x0_q < x1_q);
        syn_d   = !(y0_q < y1_q);
        cx_d    = x0_q;
        cy_d    = y0_q;
        state_d = DRAW;
      end
      DRAW: begin
        if (step) begin
          if (at_end) begin
            state_d = DONE;
          end else begin
            err_d = err_q
                  + (step_x ? dy_q : '0)
                  + (step_y ? dx_q : '0);
            if (step_x) begin
              cx_d = sxn_q ? cx_q - ONE
                           : cx_q + ONE;
            end
            if (step_y) begin
              cy_d = syn_q ? cy_q - ONE
                           : cy_q + ONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    line_ready_d = (state_d == IDLE);
`ifdef RAST_BOUNDS_CHECK_EN
    pix_valid_d  = (state_d == DRAW) &&
                   on_screen(cx_d, cy_d);
`else
    pix_valid_d  = (state_d == DRAW);
`endif
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      err_q        <= '0;
      sxn_q        <= 1'b0;
      syn_q        <= 1'b0;
      pix_valid_q  <= 1'b0;
      line_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      err_q        <= err_d;
      sxn_q        <= sxn_d;
      syn_q        <= syn_d;
      pix_valid_q  <= pix_valid_d;
      line_ready_q <= line_ready_d;
    end
  end

  assign seg.line_ready = line_ready_q;
  assign pix.pix_valid  = pix_valid_q;
  assign pix.pix_x      = cx_q;
  assign pix.pix_y      = cy_q;
  assign busy           = (state_q != IDLE);
  assign line_done      = (state_q == DONE);

endmodule

// File: tb/tb_line_rasterizer.sv
// Randomized bench for line_rasterizer with an
// integer Bresenham reference model.
module tb_line_rasterizer;

  typedef logic [31:0] pt_t;
  typedef pt_t pt_q_t[$];

`ifdef RAST_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clkin;
  logic rst_n;
  logic busy;
  logic line_done;

  line_if #(.COORD_W(16)) seg ();
  pix_if  #(.COORD_W(16)) pix ();

  line_rasterizer #(
    .COORD_W (16),
    .SCREEN_W(640),
    .SCREEN_H(480)
  ) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .seg      (seg),
    .pix      (pix),
    .busy     (busy),
    .line_done(line_done)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int    passed = 0;
  int    total  = 0;
  int    done_seen = 0;
  int    acc_cnt = 0;
  int    rmode = 0;
  int    ph = 0;
  pt_q_t exp_q;
  bit    prev_stall = 1'b0;
  pt_t   prev_pt;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h required %0h",
                  nm, act, req);
  endtask

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit onscr(int x, int y);
    return x >= 0 && x < 640 && y >= 0 && y < 480;
  endfunction

  // Pixel list a segment must produce.
  function automatic void model(input int x0, input int y0,
                                input int x1, input int y1,
                                input bit filt,
                                output pt_q_t q);
    int dx, dy, sx, sy, err, e2, x, y;
    q   = {};
    dx  = iabs(x1 - x0);
    dy  = -iabs(y1 - y0);
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    for (int n = 0; n < 100000; n++) begin
      if (!filt || onscr(x, y))
        q.push_back({16'(x), 16'(y)});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  always @(posedge clkin) begin
    #1;
    case (rmode)
      1: begin
        pix.pix_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end
      2: pix.pix_ready = ($urandom_range(0, 3) != 0);
      default: pix.pix_ready = 1'b1;
    endcase
  end

  always @(negedge clkin) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk(pix.pix_valid &&
            {pix.pix_x, pix.pix_y} == prev_pt,
            "stall_hold", {pix.pix_x, pix.pix_y},
            prev_pt);
      if (busy)
        chk(!seg.line_ready, "ready_low_busy",
            seg.line_ready, 0);
      if (pix.pix_valid && pix.pix_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0)
          chk(1'b0, "extra_pixel",
              {pix.pix_x, pix.pix_y}, 0);
        else begin
          pt_t e;
          e = exp_q.pop_front();
          chk({pix.pix_x, pix.pix_y} == e, "pixel",
              {pix.pix_x, pix.pix_y}, e);
        end
      end
      if (line_done) done_seen++;
      prev_stall = pix.pix_valid && !pix.pix_ready;
      prev_pt    = {pix.pix_x, pix.pix_y};
    end
  end

  task automatic drive_seg(int x0, int y0, int x1, int y1);
    int c;
    c = 0;
    @(posedge clkin); #1;
    while (!seg.line_ready && c < 50) begin
      @(posedge clkin); #1;
      c++;
    end
    if (c >= 50) chk(1'b0, "ready_timeout", 0, 1);
    seg.line_valid = 1'b1;
    seg.x0_in = 16'(x0);
    seg.y0_in = 16'(y0);
    seg.x1_in = 16'(x1);
    seg.y1_in = 16'(y1);
    @(posedge clkin); #1;
    seg.line_valid = 1'b0;
    seg.x0_in = 16'($urandom);
    seg.y0_in = 16'($urandom);
    seg.x1_in = 16'($urandom);
    seg.y1_in = 16'($urandom);
  endtask

  task automatic run_seg(int x0, int y0, int x1, int y1,
                         int mode);
    int d0, c, budget;
    model(x0, y0, x1, y1, BOUNDS, exp_q);
    rmode  = mode;
    budget = 8 * (iabs(x1 - x0) + iabs(y1 - y0)) + 40;
    d0 = done_seen;
    drive_seg(x0, y0, x1, y1);
    c = 0;
    while (done_seen == d0 && c < budget) begin
      @(posedge clkin); #1;
      c++;
    end
    chk(done_seen == d0 + 1, "line_done", done_seen - d0, 1);
    chk(exp_q.size() == 0, "missing_pixels",
        exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    pt_q_t q, qs;
    pt_t   lit[8];
    int    x0, y0, x1, y1, d0, a0, c;
    bit    ok;

    rst_n = 1'b0;
    seg.line_valid = 1'b0;
    seg.x0_in = '0;
    seg.y0_in = '0;
    seg.x1_in = '0;
    seg.y1_in = '0;
    repeat (3) @(posedge clkin);
    #1;
    chk(seg.line_ready == 1'b0, "rst_ready", seg.line_ready, 0);
    chk(pix.pix_valid == 1'b0, "rst_valid", pix.pix_valid, 0);
    chk({pix.pix_x, pix.pix_y} == 32'h0, "rst_xy",
        {pix.pix_x, pix.pix_y}, 0);
    chk(busy == 1'b0 && line_done == 1'b0, "rst_busy_done",
        {busy, line_done}, 0);
    rst_n = 1'b1;
    @(posedge clkin); #1;
    chk(seg.line_ready == 1'b1, "idle_ready", seg.line_ready, 1);

    // Degenerate segment, exact cycle timing.
    model(0, 0, 0, 0, BOUNDS, exp_q);
    chk(exp_q.size() == 1, "model_degen_n", exp_q.size(), 1);
    rmode = 0;
    seg.line_valid = 1'b1;
    seg.x0_in = '0;
    seg.y0_in = '0;
    seg.x1_in = '0;
    seg.y1_in = '0;
    @(posedge clkin); #1;
    seg.line_valid = 1'b0;
    @(negedge clkin);
    chk(busy && !pix.pix_valid, "setup_cycle",
        {busy, pix.pix_valid}, 2'b10);
    @(negedge clkin);
    chk(pix.pix_valid && {pix.pix_x, pix.pix_y} == 32'h0,
        "first_pix", {pix.pix_valid, pix.pix_x, pix.pix_y},
        33'h1_0000_0000);
    @(negedge clkin);
    chk(line_done && !pix.pix_valid, "done_cycle",
        {line_done, pix.pix_valid}, 2'b10);
    @(negedge clkin);
    chk(seg.line_ready && !line_done, "ready_back",
        {seg.line_ready, line_done}, 2'b10);
    chk(exp_q.size() == 0, "degen_count", exp_q.size(), 0);

    // Literal pins on the model.
    model(0, 0, 5, 2, 1'b0, q);
    lit[0] = {16'd0, 16'd0}; lit[1] = {16'd1, 16'd0};
    lit[2] = {16'd2, 16'd1}; lit[3] = {16'd3, 16'd1};
    lit[4] = {16'd4, 16'd2}; lit[5] = {16'd5, 16'd2};
    ok = (q.size() == 6);
    for (int i = 0; i < 6 && ok; i++) ok = (q[i] == lit[i]);
    chk(ok, "model_5_2", q.size(), 6);
    run_seg(0, 0, 5, 2, 0);

    model(3, 7, 0, 0, 1'b0, q);
    lit[0] = {16'd3, 16'd7}; lit[1] = {16'd3, 16'd6};
    lit[2] = {16'd2, 16'd5}; lit[3] = {16'd2, 16'd4};
    lit[4] = {16'd1, 16'd3}; lit[5] = {16'd1, 16'd2};
    lit[6] = {16'd0, 16'd1}; lit[7] = {16'd0, 16'd0};
    ok = (q.size() == 8);
    for (int i = 0; i < 8 && ok; i++) ok = (q[i] == lit[i]);
    chk(ok, "model_3_7_rev", q.size(), 8);
    model(0, 0, 3, 7, 1'b0, qs);
    ok = (qs.size() == 8);
    for (int i = 0; i < 8 && ok; i++) ok = (qs[i] == q[7 - i]);
    chk(ok, "model_swap_set", qs.size(), 8);
    run_seg(3, 7, 0, 0, 0);

    // Stalls with a 1,0,0 ready pattern.
    ph = 0;
    run_seg(0, 0, 10, 0, 1);

    // Bounds behaviour.
    model(-2, 5, 2, 5, BOUNDS, q);
    chk(q.size() == (BOUNDS ? 3 : 5), "model_bounds_lo",
        q.size(), BOUNDS ? 3 : 5);
    run_seg(-2, 5, 2, 5, 0);
    model(630, 470, 650, 490, BOUNDS, q);
    chk(q.size() == (BOUNDS ? 10 : 21), "model_bounds_hi",
        q.size(), BOUNDS ? 10 : 21);
    run_seg(630, 470, 650, 490, 2);

    // Abort mid-segment with reset.
    model(0, 0, 20, 20, BOUNDS, exp_q);
    rmode = 0;
    d0 = done_seen;
    a0 = acc_cnt;
    drive_seg(0, 0, 20, 20);
    c = 0;
    while (acc_cnt < a0 + 4 && c < 40) begin
      @(posedge clkin); #1;
      c++;
    end
    chk(acc_cnt >= a0 + 4, "abort_progress", acc_cnt - a0, 4);
    rst_n = 1'b0;
    #1;
    chk(!pix.pix_valid && !busy, "abort_idle",
        {pix.pix_valid, busy}, 0);
    repeat (3) @(posedge clkin);
    #1;
    chk(!line_done, "abort_no_done", line_done, 0);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clkin);
    #1;
    chk(done_seen == d0, "abort_no_done_cnt",
        done_seen - d0, 0);
    run_seg(2, 3, 9, 1, 0);

    // Randomized segments.
    for (int s = 0; s < 24; s++) begin
      x0 = int'($urandom_range(0, 140)) - 20;
      y0 = int'($urandom_range(0, 140)) - 20;
      x1 = int'($urandom_range(0, 140)) - 20;
      y1 = int'($urandom_range(0, 140)) - 20;
      model(x0, y0, x1, y1, 1'b0, q);
      model(x1, y1, x0, y0, 1'b0, qs);
      c = ((iabs(x1 - x0) > iabs(y1 - y0)) ?
           iabs(x1 - x0) : iabs(y1 - y0)) + 1;
      chk(q.size() == c && qs.size() == c &&
          q[0] == {16'(x0), 16'(y0)} &&
          q[q.size() - 1] == {16'(x1), 16'(y1)},
          "model_props", q.size(), c);
      run_seg(x0, y0, x1, y1, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/line_rasterizer.md
# line_rasterizer

Bresenham line walker directly downstream of the clipper inside `vpu_top`. Accepts one clipped segment (x0, y0, x1, y1) per handshake and emits every pixel coordinate on that segment, one per cycle, to the frame-buffer writer. A valid/ready handshake sits on both sides, and the pixel stream supports back-pressure.

## Interface
- `COORD_W`, default 16: signed coordinate width. Matches the clipper's x0/y0/x1/y1 outputs.
- `SCREEN_W`, default 640: horizontal pixel count. Used only with the bounds-check macro.
- `SCREEN_H`, default 480: vertical pixel count. Used only with the bounds-check macro.

Ports (name, direction, width, meaning):
- `clkin`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `line_valid`, in, 1: the clipper presents a segment.
- `line_ready`, out, 1: the rasterizer can accept a segment.
- `x0_in`, `y0_in`, `x1_in`, `y1_in`, in, COORD_W each: segment endpoints, two's complement.
- `pix_valid`, out, 1: `pix_x`/`pix_y` hold a pixel.
- `pix_ready`, in, 1: the downstream writer accepts the pixel.
- `pix_x`, `pix_y`, out, COORD_W each: current pixel coordinate.
- `busy`, out, 1: a segment is in progress (state ≠ IDLE).
- `line_done`, out, 1: one-cycle pulse when a segment completes.

## Operation
- States: IDLE, SETUP, DRAW, DONE.
- IDLE
  - `line_ready`=1.
  - On `line_valid && line_ready`: latch the endpoints, go to SETUP.
- SETUP (1 cycle): compute and register the walker state.
  - dx = |x1−x0|.
  - dy = −|y1−y0|.
  - sx = +1 if x0<x1, else −1.
  - sy = +1 if y0<y1, else −1.
  - err = dx+dy.
  - Current point = (x0, y0).
  - Then go to DRAW.
- Internal width: dx, dy and err are COORD_W+2 bits, signed. e2 = 2·err is COORD_W+3 bits. No intermediate value may saturate or wrap.
- DRAW
  - `pix_valid`=1 with the current point.
  - The point is held stable while `pix_ready`=0.
  - On acceptance, if the current point equals (x1, y1), go to DONE. Otherwise:
    - if e2 ≥ dy: err += dy and x += sx;
    - if e2 ≤ dx: err += dx and y += sy.
    - Both updates use the same pre-update err.
- DONE (1 cycle): `line_done`=1, then go to IDLE.
- Pixel count per segment = max(|x1−x0|, |y1−y0|) + 1.
- A degenerate segment (x0=x1, y0=y1) emits exactly one pixel.
- Direction independence: a segment and its endpoint-swapped copy emit the same number of pixels. Endpoints are always included.
- Input endpoints are ignored outside the IDLE accept cycle. A change on the inputs mid-segment has no effect.
- Reset, at any time (including mid-segment): return to IDLE immediately. The segment is aborted and no `line_done` is produced.
- Reset values of outputs:
  - `line_ready`=0 while `rst_n`=0, then 1 in IDLE.
  - `pix_valid`=0, `pix_x`=0, `pix_y`=0.
  - `busy`=0, `line_done`=0.

## Timing
- Accept at edge N → SETUP in cycle N+1 → first `pix_valid` in cycle N+2.
- With `pix_ready` held at 1: one pixel per cycle. The last pixel is accepted at edge M, `line_done` is high in cycle M+1, and `line_ready` is high in cycle M+2.
- Per-segment overhead is 3 cycles (SETUP, DONE, IDLE accept). Segment throughput = pixels + 3 cycles.
- `pix_valid` never drops while a pixel is pending.
- `pix_valid`, `pix_x` and `pix_y` are all registered. No combinational path from `pix_ready` to the pixel outputs.
- `line_ready` is a registered decode of IDLE. No combinational path from `line_valid` to `line_ready`.

## Configuration
- `RAST_BOUNDS_CHECK_EN`
  - Defined:
    - A point with x<0, x≥SCREEN_W, y<0 or y≥SCREEN_H is not presented. `pix_valid`=0 for that step and the walker advances one step per cycle without waiting on `pix_ready`.
    - The endpoint test still terminates the segment even if (x1, y1) is off-screen.
  - Undefined: every point is presented regardless of value. The bounds logic and the SCREEN_W/SCREEN_H comparisons are absent.

## Test plan
- Reset, then `line_valid` with (0,0)→(0,0), `pix_ready`=1.
  - Expect exactly one pixel (0,0) in cycle N+2, `line_done` in N+3, `line_ready` back in N+4.
- Segment (0,0)→(5,2), `pix_ready`=1.
  - Expect 6 pixels: (0,0),(1,0),(2,1),(3,1),(4,2),(5,2). Then one `line_done` pulse.
- Segment (3,7)→(0,0), steep with negative steps.
  - Expect 8 pixels from (3,7) to (0,0), y stepping −1 every pixel. The pixel set equals that of (0,0)→(3,7).
- Segment (0,0)→(10,0) with `pix_ready` toggling 1,0,0,1,…
  - Expect 11 pixels, in order, with no duplicates or skips.
  - Expect `pix_x`/`pix_y` stable throughout each stall.
- Assert `rst_n`=0 mid-segment after 4 pixels of (0,0)→(20,20).
  - Expect `pix_valid`=0 and `busy`=0 immediately, and no `line_done`.
  - A new segment is accepted normally after reset.
- With `RAST_BOUNDS_CHECK_EN`, segment (−2,5)→(2,5).
  - Expect only (0,5),(1,5),(2,5) presented, and `line_done` asserted.
  - Without the macro, expect all 5 pixels.
